// File: rtl/seg7hex_bank.sv
// Multi-digit hex 7-segment driver: registered display value, active-low decode, per-digit blink.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7hex_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   leds,
  output logic                  loaded
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [4*DIGITS-1:0] disp;
  logic [CW-1:0]       cnt;
  logic                phase;
  logic [7*DIGITS-1:0] leds_next;
  logic [DIGITS-1:0]   lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen        = seen | (disp[4*i +: 4] != 4'h0);
      lz_blank[i] = !seen && (i != 0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    leds_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (lz_blank[i] || (!phase && blink_mask[i]))
        leds_next[7*i +: 7] = SEG_BLANK;
      else
        leds_next[7*i +: 7] = decode(disp[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      disp   <= '0;
      cnt    <= '0;
      phase  <= 1'b1;
      leds   <= {DIGITS{SEG_ZERO}};
      loaded <= 1'b0;
    end else begin
      if (load)
        disp <= value;
      loaded <= load;
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
      leds <= leds_next;
    end
  end

endmodule

// File: tb/tb_seg7hex_bank.sv
// Self-checking bench for seg7hex_bank (DIGITS=6, BLINK_DIV=4) against a cycle-level reference model.
module tb_seg7hex_bank;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [4*DIGITS-1:0] value = '0;
  logic                load = 1'b0;
  logic [DIGITS-1:0]   blink_mask = '0;
  logic [7*DIGITS-1:0] leds;
  logic                loaded;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: captured value and number of running edges since the last reset.
  logic [4*DIGITS-1:0] m_disp = '0;
  int                  m_n = 0;
  logic [7*DIGITS-1:0] exp_leds;
  logic                exp_loaded;

  seg7hex_bank #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .blink_mask(blink_mask), .leds(leds), .loaded(loaded)
  );

  always #5 clk = ~clk;

  function automatic logic phase_of(input int n);
    return ((n / BLINK_DIV) % 2) == 0;
  endfunction

  function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] v,
                                                 input logic ph, input logic [DIGITS-1:0] m);
    logic [7*DIGITS-1:0] r;
    int hi;
    hi = 0;
`ifdef SEG7_LZ_BLANK_EN
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'h0) hi = i;
`else
    hi = DIGITS - 1;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (i > hi || (!ph && m[i])) r[7*i +: 7] = 7'h7f;
      else r[7*i +: 7] = seg_tab[v[4*i +: 4]];
    end
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic tick(input logic r, input logic l, input logic [4*DIGITS-1:0] v,
                      input logic [DIGITS-1:0] m);
    reset = r; load = l; value = v; blink_mask = m;
    exp_leds = render(m_disp, phase_of(m_n), m);
    if (!r) begin
      m_disp = '0; m_n = 0; exp_leds = {DIGITS{7'b1000000}}; exp_loaded = 1'b0;
    end else begin
      if (l) m_disp = v;
      exp_loaded = l;
      m_n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b1, 24'hFFFFFF, '0);
    checks++;
    if (leds !== {DIGITS{7'b1000000}}) begin
      errors++; $display("[TB] FAIL reset_leds: got %h expected %h", leds, {DIGITS{7'b1000000}});
    end
    checks++;
    if (loaded !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_loaded: got %b expected 0", loaded);
    end
  endtask

  task automatic test_load;
    logic [7*DIGITS-1:0] want;
`ifdef SEG7_LZ_BLANK_EN
    want = {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0001110};
`else
    want = {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0001110};
`endif
    tick(1'b1, 1'b1, 24'h0123AF, '0);
    checks++;
    if (loaded !== 1'b1) begin
      errors++; $display("[TB] FAIL load_ack: got %b expected 1", loaded);
    end
    tick(1'b1, 1'b0, 24'h555555, '0);
    checks++;
    if (loaded !== 1'b0) begin
      errors++; $display("[TB] FAIL load_ack_drop: got %b expected 0", loaded);
    end
    checks++;
    if (leds !== want) begin
      errors++; $display("[TB] FAIL load_leds: got %h expected %h", leds, want);
    end
  endtask

  task automatic test_sweep;
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 1'b1, {20'h0123A, 4'(k)}, '0);
      tick(1'b1, 1'b0, '0, '0);
      checks++;
      if (leds[6:0] !== seg_tab[k]) begin
        errors++; $display("[TB] FAIL sweep_digit0_%0d: got %b expected %b", k, leds[6:0], seg_tab[k]);
      end
      checks++;
      if (leds !== exp_leds) begin
        errors++; $display("[TB] FAIL sweep_all_%0d: got %h expected %h", k, leds, exp_leds);
      end
    end
  endtask

  task automatic test_blink;
    int blanks;
    blanks = 0;
    tick(1'b1, 1'b1, 24'h0123AF, '0);
    for (int c = 0; c < 16; c++) begin
      tick(1'b1, 1'b0, '0, 6'b000001);
      checks++;
      if (leds !== exp_leds) begin
        errors++; $display("[TB] FAIL blink_c%0d: got %h expected %h", c, leds, exp_leds);
      end
      if (leds[6:0] === 7'h7f) blanks++;
    end
    checks++;
    if (blanks < 4 || blanks > 12) begin
      errors++; $display("[TB] FAIL blink_alternates: blank cycles %0d expected 4..12", blanks);
    end
  endtask

  task automatic test_reset_mid;
    int guard;
    guard = 0;
    // Advance until the next rendered cycle is in the blank phase.
    while (phase_of(m_n) && guard < 20) begin
      tick(1'b1, 1'b0, '0, 6'b000001);
      guard++;
    end
    tick(1'b1, 1'b0, '0, 6'b000001);
    checks++;
    if (leds[6:0] !== 7'h7f) begin
      errors++; $display("[TB] FAIL midreset_preblank: got %b expected 1111111", leds[6:0]);
    end
    tick(1'b0, 1'b0, '0, 6'b000001);
    checks++;
    if (leds !== {DIGITS{7'b1000000}}) begin
      errors++; $display("[TB] FAIL midreset_leds: got %h expected %h", leds, {DIGITS{7'b1000000}});
    end
    for (int c = 1; c <= 8; c++) begin
      tick(1'b1, 1'b0, '0, 6'b000001);
      checks++;
      if (leds[6:0] !== ((c <= 4) ? 7'b1000000 : 7'h7f)) begin
        errors++; $display("[TB] FAIL midreset_phase_c%0d: got %b expected %b", c, leds[6:0],
                           (c <= 4) ? 7'b1000000 : 7'h7f);
      end
    end
  endtask

  task automatic test_boundary;
    int seen_blank;
    seen_blank = 0;
    while ((m_n % BLINK_DIV) != BLINK_DIV - 1) tick(1'b1, 1'b0, '0, '1);
    tick(1'b1, 1'b1, 24'hFEDCBA, '1);
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0, '0, '1);
      checks++;
      if (leds !== exp_leds) begin
        errors++; $display("[TB] FAIL boundary_c%0d: got %h expected %h", c, leds, exp_leds);
      end
      if (leds === {7*DIGITS{1'b1}}) seen_blank++;
    end
    checks++;
    if (seen_blank == 0) begin
      errors++; $display("[TB] FAIL allmask_blank: got %0d blank cycles expected >0", seen_blank);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 80; c++) begin
      tick(($urandom_range(0, 29) != 0), ($urandom_range(0, 2) == 0),
           24'($urandom), 6'($urandom));
      checks++;
      if (leds !== exp_leds || loaded !== exp_loaded) begin
        errors++; $display("[TB] FAIL random_c%0d: got %h/%b expected %h/%b",
                           c, leds, loaded, exp_leds, exp_loaded);
      end
    end
  endtask

  task automatic test_lz;
    logic [7*DIGITS-1:0] want;
`ifdef SEG7_LZ_BLANK_EN
    want = {{4{7'b1111111}}, 7'b0001000, 7'b1000000};
`else
    want = {{4{7'b1000000}}, 7'b0001000, 7'b1000000};
`endif
    tick(1'b1, 1'b1, 24'h0000A0, '0);
    tick(1'b1, 1'b0, '0, '0);
    checks++;
    if (leds !== want) begin
      errors++; $display("[TB] FAIL lz_a0: got %h expected %h", leds, want);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_sweep;
    test_blink;
    test_reset_mid;
    test_boundary;
    test_random;
    tick(1'b0, 1'b0, '0, '0);
    test_lz;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
